// File: rtl/expr_regr_pkg.sv
// Shared types and constants for the expression-regression result checker.
//   state_t     : control states of the result MISR
//   MISR_POLY   : default MISR feedback polynomial
//   MISR_SEED   : default signature seed
//   fold_chunks : padded width when folding a data_w vector into sig_w chunks
package expr_regr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  // Round data_w up to a whole number of sig_w chunks.
  function automatic int unsigned fold_chunks(input int unsigned data_w,
                                              input int unsigned sig_w);
    return ((data_w + sig_w - 1) / sig_w) * sig_w;
  endfunction

endpackage

// File: rtl/expr_fold_xor.sv
// Folds a DATA_W result vector into SIG_W bits by XOR-ing its zero-padded
// SIG_W-bit chunks. Purely combinational.
// Ports:
//   data     in  DATA_W  result vector
//   folded_c out SIG_W   XOR of all chunks
module expr_fold_xor
  import expr_regr_pkg::*;
#(
  parameter int unsigned DATA_W = 90,
  parameter int unsigned SIG_W  = 32
) (
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  folded_c
);

  localparam int unsigned PAD_W = fold_chunks(DATA_W, SIG_W);
  localparam int unsigned NCH   = PAD_W / SIG_W;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(data);

  // XOR reduction across chunks
  always_comb begin
    folded_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      folded_c = folded_c ^ padded[i*SIG_W +: SIG_W];
    end
  end

endmodule

// File: rtl/expr_result_misr.sv
// Consumes a counted stream of expression results over valid/ready,
// compresses them into a MISR signature and compares it against an
// expected signature at the end of the run.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         begin a run (IDLE only), vec_count sampled with it
//   exp_sig       expected signature, sampled in the DONE cycle
//   in_valid/in_data/in_ready  result vector handshake
//   busy          run in progress (RUN or DONE)
//   done          one-cycle end-of-run pulse
//   pass          last run's signature matched, held until next start
//   sig_out       current signature register
module expr_result_misr
  import expr_regr_pkg::*;
#(
  parameter int unsigned       DATA_W = 90,
  parameter int unsigned       SIG_W  = 32,
  parameter logic [SIG_W-1:0]  POLY   = SIG_W'(MISR_POLY),
  parameter logic [SIG_W-1:0]  SEED   = SIG_W'(MISR_SEED),
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  vec_count,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  sig_out
);

  state_t             state, state_nxt;
  logic [SIG_W-1:0]   sig, sig_nxt;
  logic [CNT_W-1:0]   remaining, remaining_nxt;
  logic               pass_r, pass_nxt;
  logic [SIG_W-1:0]   folded;
  logic [SIG_W-1:0]   misr_step;

  expr_fold_xor #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W)
  ) u_fold (
    .data     (in_data),
    .folded_c (folded)
  );

  // Galois-style shift with polynomial feedback, then inject folded data
  assign misr_step = {sig[SIG_W-2:0], 1'b0}
                   ^ (sig[SIG_W-1] ? POLY : '0)
                   ^ folded;

  // Handshake and status are direct decodes of the state register
  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign pass     = pass_r;
  assign sig_out  = sig;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sig       <= SEED;
      remaining <= '0;
      pass_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sig       <= sig_nxt;
      remaining <= remaining_nxt;
      pass_r    <= pass_nxt;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_nxt     = state;
    sig_nxt       = sig;
    remaining_nxt = remaining;
    pass_nxt      = pass_r;
    unique case (state)
      IDLE: begin
        if (start) begin
          sig_nxt       = SEED;
          remaining_nxt = vec_count;
          pass_nxt      = 1'b0;
          state_nxt     = (vec_count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // in_ready is high throughout RUN, so valid alone means transfer
        if (in_valid) begin
          sig_nxt       = misr_step;
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        pass_nxt  = (sig == exp_sig);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_expr_result_misr.sv
// Scoreboard bench for expr_result_misr: stimulus pushes the expected
// end-of-run result, a monitor pops and compares on every done pulse.
module tb_expr_result_misr;

  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] ZSIG = 32'hFB3EE249;

  typedef struct packed {
    logic [31:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] vec_count;
  logic [31:0] exp_sig;
  logic        in_valid;
  logic [89:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] sig_out;

  int checks = 0;
  int errors = 0;
  int xfer   = 0;
  exp_t q[$];

  expr_result_misr dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vec_count (vec_count),
    .exp_sig   (exp_sig),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .sig_out   (sig_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_fold(input logic [89:0] x);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 90; i++) f[i % 32] = f[i % 32] ^ x[i];
    return f;
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [89:0] x);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ POLY;
    return n ^ model_fold(x);
  endfunction

  function automatic logic [89:0] rnd90();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[89:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Count accepted transfers since the last start (handshake stable at negedge)
  always @(negedge clk) begin
    if (reset === 1'b1) xfer = 0;
    else if (start === 1'b1 && busy === 1'b0) xfer = 0;
    else if (in_valid === 1'b1 && in_ready === 1'b1) xfer = xfer + 1;
  end

  // Monitor: every done pulse must match the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = q.pop_front();
          check("done_sig", sig_out, e.sig);
          check("done_xfers", 32'(xfer), 32'(e.cnt));
          check("done_in_ready", {31'b0, in_ready}, 32'd0);
          @(negedge clk);
          check("pass", {31'b0, pass}, {31'b0, e.pass});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n, input logic [31:0] e);
    vec_count = n;
    exp_sig   = e;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [89:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) check("send_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", {31'b0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [89:0] d;
    logic [89:0] bd[6];
    logic [5:0]  pat;
    logic [31:0] m;

    reset = 1'b1; start = 1'b0; vec_count = '0; exp_sig = '0;
    in_valid = 1'b0; in_data = '0;
    tick();
    tick();
    check("rst_sig", sig_out, SEED);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_pass", {31'b0, pass}, 32'd0);
    reset = 1'b0;
    tick();

    // Zero-length run: done right after start, seed untouched
    q.push_back('{sig: SEED, pass: 1'b1, cnt: 16'd0});
    do_start(16'd0, SEED);
    check("zero_busy", {31'b0, busy}, 32'd1);
    wait_idle();

    // Single zero vector, matching and non-matching expected signature
    q.push_back('{sig: ZSIG, pass: 1'b1, cnt: 16'd1});
    do_start(16'd1, ZSIG);
    send('0);
    wait_idle();
    q.push_back('{sig: ZSIG, pass: 1'b0, cnt: 16'd1});
    do_start(16'd1, 32'h0);
    send('0);
    wait_idle();

    // Bits 0 and 64 land in the same chunk position and cancel
    d = '0; d[0] = 1'b1; d[64] = 1'b1;
    q.push_back('{sig: ZSIG, pass: 1'b1, cnt: 16'd1});
    do_start(16'd1, ZSIG);
    send(d);
    wait_idle();

    // Bubbles, ignored mid-run start, vector offered during DONE
    pat = 6'b101001;  // cycle i uses pat[i]: 1,0,0,1,0,1
    m = SEED;
    for (int i = 0; i < 6; i++) begin
      bd[i] = rnd90();
      if (pat[i]) m = model_step(m, bd[i]);
    end
    q.push_back('{sig: m, pass: 1'b1, cnt: 16'd3});
    do_start(16'd3, m);
    for (int i = 0; i < 6; i++) begin
      in_valid  = pat[i];
      in_data   = bd[i];
      start     = (i == 1);
      vec_count = (i == 1) ? 16'd7 : 16'd3;
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = rnd90();
    check("bp_done_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("bp_idle", {31'b0, busy}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_sig_hold", sig_out, m);
    tick();

    // Mid-run reset abandons the run without a done pulse
    do_start(16'd5, 32'h0);
    send(rnd90());
    send(rnd90());
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_sig", sig_out, SEED);
    check("mr_done", {31'b0, done}, 32'd0);
    check("mr_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    tick();
    q.push_back('{sig: ZSIG, pass: 1'b1, cnt: 16'd1});
    do_start(16'd1, ZSIG);
    send('0);
    wait_idle();

    tick();
    tick();
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_result_misr.md
Name: expr_result_misr

Overview:
- Downstream consumer for the 90-bit `y` result bus of the vloghammer expression blocks.
- Accepts a counted stream of result vectors over a valid/ready handshake and compresses them into a 32-bit MISR signature.
- At the end of the run it compares the signature against an expected value and reports pass/fail.
- Lets LiveHD regression compare an expression module against its golden netlist with one 32-bit word instead of 90 bits per vector.

Parameters:
- DATA_W, 90, width of the result vector (`y` bus of the expression block).
- SIG_W, 32, MISR/signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial (SIG_W bits).
- SEED, 32'hFFFFFFFF, signature value loaded at reset and at start.
- CNT_W, 16, width of the vector counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- vec_count  input  CNT_W  number of vectors in the run; sampled with start.
- exp_sig  input  SIG_W  expected signature; sampled in the DONE cycle.
- in_valid  input  1  result vector valid.
- in_data  input  DATA_W  result vector (`y`).
- in_ready  output  1  block accepts in_data this cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  sig_out==exp_sig at last done; held until next start.
- sig_out  output  SIG_W  current signature register.

Behaviour:
- Reset (synchronous, active-high, has priority over everything):
  - state=IDLE, sig=SEED, remaining=0, done=0, pass=0.
  - in_ready=0 and busy=0 follow combinationally from IDLE.
  - A reset in the middle of a run abandons the run; no done pulse.
- States: IDLE, RUN, DONE. Outputs in_ready=(state==RUN), busy=(state!=IDLE), done=(state==DONE).
- IDLE, start=1:
  - sig<=SEED, remaining<=vec_count, pass<=0.
  - Next state is RUN if vec_count!=0, otherwise DONE.
- IDLE, start=0: hold all registers; sig_out and pass keep the last run's values.
- RUN: a transfer occurs when in_valid && in_ready. On a transfer:
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold(in_data).
  - remaining <= remaining-1.
  - If remaining==1, next state is DONE.
- RUN with no transfer: hold. Bubbles of any length are allowed; in_data is ignored when in_valid=0.
- fold(x):
  - Zero-extend x to ceil(DATA_W/SIG_W)*SIG_W bits (96 for the defaults).
  - XOR all SIG_W-bit chunks: x[31:0]^x[63:32]^{6'b0,x[89:64]}.
  - Purely combinational; adds no latency.
- DONE (lasts exactly one cycle):
  - done=1, in_ready=0.
  - pass<=(sig==exp_sig), where sig is the final signature.
  - Next state is IDLE.
- Latency: done rises the cycle after the last accepted vector. With vec_count=0, done rises the cycle after start.
- pass becomes visible the cycle after done and holds until the next start.
- start while busy is ignored.
- No wrap-around: remaining never decrements below 0, because RUN is only entered with remaining>=1.
- The count is exact. in_ready drops in DONE, so a vector offered during DONE is not consumed.

Decomposition:
- Package expr_regr_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default POLY and SEED constants;
  - function fold_chunks(DATA_W, SIG_W) that returns the padded width.
- One combinational sub-module, expr_fold_xor (DATA_W, SIG_W → SIG_W), implements fold().
- Everything else (FSM, counter, MISR register, compare) lives in expr_result_misr.

Test Plan:
- Reset check: reset=1 for 2 cycles → sig_out=32'hFFFFFFFF, in_ready=0, busy=0, done=0, pass=0.
- Zero-length run: start with vec_count=0 → done one cycle later, sig_out=32'hFFFFFFFF; pass=1 when exp_sig=32'hFFFFFFFF.
- Single zero vector: vec_count=1, in_data=0 → sig_out=32'hFB3EE249, done the next cycle; pass=1 with that exp_sig, pass=0 with exp_sig=0.
- Fold cancellation: vec_count=1, in_data with bit0 and bit64 set → fold=0, sig_out=32'hFB3EE249.
- Backpressure and bubbles: vec_count=3, in_valid toggling 1,0,0,1,0,1 with random data → exactly 3 transfers.
  - sig_out matches the reference-model MISR.
  - A vector held valid during DONE is not consumed.
  - start pulsed mid-run is ignored.
- Mid-run reset: reset after 2 of 5 vectors → no done pulse, IDLE next cycle, sig_out=SEED.
  - A new run with vec_count=1, in_data=0 gives 32'hFB3EE249.
